prog_memory: RTL and testbench
==============================

PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning MAR and address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM word and bus width.
REQ-003 SHALL have parameter CLEAR_ON_RST, default 1, meaning 1 = zero-fill all RAM words after reset, 0 = skip the fill.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have the port load, input, 1 bit: latch bus[ADDR_W-1:0] into MAR.
REQ-007 SHALL have the port write, input, 1 bit: write bus into ram[MAR].
REQ-008 SHALL have the port inc, input, 1 bit: increment MAR by one (run mode).
REQ-009 SHALL have the port bus, input, DATA_W bits: run-mode data and address source.
REQ-010 SHALL have the port prog, input, 1 bit: level request for program mode.
REQ-011 SHALL have the port prog_valid, input, 1 bit: a program word is present on prog_data.
REQ-012 SHALL have the port prog_data, input, DATA_W bits: the program word.
REQ-013 SHALL have the port prog_ready, output, 1 bit: the block accepts program words.
REQ-014 SHALL have the port prog_done, output, 1 bit: one-cycle pulse when the last address is programmed.
REQ-015 SHALL have the port busy, output, 1 bit: high while the clear sequence runs.
REQ-016 SHALL have the port mar_out, output, ADDR_W bits: the current MAR value.
REQ-017 SHALL have the port out, output, DATA_W bits: ram[MAR], combinational asynchronous read.

Function
REQ-018 SHALL implement the FSM states CLEAR, RUN and PROG.
REQ-019 CLEAR SHALL write 0 to address clr_ptr each cycle, with clr_ptr running 0..DEPTH-1, hold busy=1, and enter RUN after exactly DEPTH cycles.
REQ-020 CLEAR and PROG SHALL ignore load, write and inc.
REQ-021 In RUN, write SHALL store bus into ram[MAR] using the pre-edge MAR.
REQ-022 In RUN, load SHALL set MAR <= bus[ADDR_W-1:0], and the upper bus bits SHALL be ignored.
REQ-023 In RUN, inc SHALL set MAR <= MAR+1 modulo DEPTH, so DEPTH-1 wraps to 0.
REQ-024 If load and inc are both high, load SHALL win.
REQ-025 If write is high together with load or inc, the write SHALL use the old MAR in the same cycle that MAR updates.
REQ-026 RUN with prog=1 SHALL move to PROG on the next edge, set MAR <= 0, and suppress any RUN action (including write) in that cycle.
REQ-027 PROG SHALL hold prog_ready=1, and prog_ready SHALL be 0 in every other state.
REQ-028 In PROG, prog_valid && prog_ready SHALL write ram[MAR] <= prog_data and set MAR <= MAR+1 modulo DEPTH.
REQ-029 The accept at MAR=DEPTH-1 SHALL assert prog_done for exactly the following cycle, and MAR SHALL wrap to 0.
REQ-030 Programming SHALL continue past the wrap and overwrite from address 0 if more words arrive.
REQ-031 PROG with prog=0 SHALL move to RUN on the next edge, set MAR <= 0, and accept no word in that cycle even if prog_valid=1.
REQ-032 A prog request during CLEAR SHALL be held off; RUN SHALL be entered first, then PROG on the following edge if prog is still 1.
REQ-033 out SHALL always equal ram[MAR], and a write SHALL become visible on out the cycle after the write edge.

Reset
REQ-034 rst=1 at a clock edge SHALL set MAR=0, prog_done=0 and prog_ready=0, from any state, including mid-CLEAR and mid-PROG.
REQ-035 Reset SHALL enter CLEAR with clr_ptr=0 and busy=1 when CLEAR_ON_RST=1, else RUN with busy=0.
REQ-036 A reset mid-CLEAR SHALL restart the fill from address 0.
REQ-037 A reset mid-PROG SHALL leave already-written words intact when CLEAR_ON_RST=0.
REQ-038 Reset SHALL NOT otherwise alter RAM contents.

Verification (ADDR_W=4, DATA_W=8, CLEAR_ON_RST=1)
REQ-039 Reset, then 16 idle cycles -> busy=1 for 16 cycles then 0; then load 0..15 one at a time -> out=0x00 at every address.
REQ-040 RUN: load bus=0x3D, write bus=0xA5 -> mar_out=0xD and out=0xA5; write 0x5A with inc in the same cycle -> ram[0xD]=0x5A, mar_out=0xE.
REQ-041 RUN: load 0xF then inc -> mar_out=0x0; load and inc high with bus=0x07 -> mar_out=0x7.
REQ-042 prog=1, stream 16 words 0x10..0x1F with prog_valid gapped every other cycle -> prog_done pulses once after word 0x1F, mar_out=0; prog=0, then load 5 -> out=0x15.
REQ-043 Assert rst after 6 program words -> next cycle prog_ready=0, busy=1, MAR=0; after 16 cycles all words read 0x00.
REQ-044 prog=1 raised during CLEAR -> prog_ready stays 0 until the cycle after busy falls, then prog_ready=1.

Source files
------------

// File: rtl/prog_memory.sv
// Program/run RAM with address register (MAR), power-up zero fill, and a
// valid/ready program-load port that streams words into consecutive addresses.
//
// state | meaning
// CLEAR | zero-fill ram[clr_ptr], busy=1, all run/prog controls ignored
// RUN   | bus-driven load/write/inc of MAR and RAM
// PROG  | prog_ready=1, each accepted word written at MAR, MAR auto-increments
module prog_memory #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              write,
  input  logic              inc,
  input  logic [DATA_W-1:0] bus,
  input  logic              prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] mar, mar_d;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_d;
  logic              done_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ram [DEPTH];

  always_comb begin
    state_d   = state;
    mar_d     = mar;
    clr_ptr_d = clr_ptr;
    done_d    = 1'b0;
    we        = 1'b0;
    waddr     = mar;
    wdata     = bus;
    case (state)
      CLEAR: begin
        we        = 1'b1;
        waddr     = clr_ptr;
        wdata     = '0;
        clr_ptr_d = clr_ptr + ADDR_W'(1);
        if (clr_ptr == '1) state_d = RUN;
      end
      RUN: begin
        if (prog) begin
          // entering program mode pre-empts any run action this cycle
          state_d = PROG;
          mar_d   = '0;
        end else begin
          we = write;
          if (load)     mar_d = bus[ADDR_W-1:0];
          else if (inc) mar_d = mar + ADDR_W'(1);
        end
      end
      PROG: begin
        if (!prog) begin
          state_d = RUN;
          mar_d   = '0;
        end else if (prog_valid) begin
          we     = 1'b1;
          wdata  = prog_data;
          mar_d  = mar + ADDR_W'(1);
          done_d = (mar == '1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      mar       <= '0;
      clr_ptr   <= '0;
      prog_done <= 1'b0;
    end else begin
      state     <= state_d;
      mar       <= mar_d;
      clr_ptr   <= clr_ptr_d;
      prog_done <= done_d;
    end
  end

  // RAM contents survive reset; only the fill sequence clears them
  always_ff @(posedge clk) begin
    if (we && !rst) ram[waddr] <= wdata;
  end

  assign prog_ready = (state == PROG);
  assign busy       = (state == CLEAR);
  assign mar_out    = mar;
  assign out        = ram[mar];

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboarded bench for prog_memory: directed scenarios plus random traffic
// checked cycle by cycle against an array-based reference model.
module tb_prog_memory;

  logic       clk = 1'b0;
  logic       rst, load, write, inc, prog, prog_valid;
  logic [7:0] bus, prog_data;
  logic       prog_ready, prog_done, busy;
  logic [3:0] mar_out;
  logic [7:0] out;

  always #5 clk = ~clk;

  prog_memory #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .load(load), .write(write), .inc(inc), .bus(bus),
    .prog(prog), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .prog_done(prog_done), .busy(busy),
    .mar_out(mar_out), .out(out)
  );

  typedef struct packed {
    logic       busy;
    logic       ready;
    logic       done;
    logic [3:0] mar;
    logic [7:0] out;
    logic       out_known;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  localparam int M_CLEAR = 0, M_RUN = 1, M_PROG = 2;
  int         mode   = M_RUN;
  int         mar_m  = 0;
  int         clr_m  = 0;
  bit         done_m = 1'b0;
  logic [7:0] mem_m [16];

  initial foreach (mem_m[i]) mem_m[i] = 'x;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy || prog_ready !== e.ready || prog_done !== e.done ||
          mar_out !== e.mar || (e.out_known && out !== e.out)) begin
        errors++;
        $display("FAIL outputs step %0d: got busy=%b ready=%b done=%b mar=%h out=%h, expected busy=%b ready=%b done=%b mar=%h out=%h (out checked=%b)",
                 nstep, busy, prog_ready, prog_done, mar_out, out,
                 e.busy, e.ready, e.done, e.mar, e.out, e.out_known);
      end
    end
  end

  task automatic model(input bit r, ld, wr, in_, input logic [7:0] b,
                       input bit p, pv, input logic [7:0] pd);
    if (r) begin
      mar_m = 0; done_m = 0; mode = M_CLEAR; clr_m = 0;
    end else begin
      done_m = 0;
      case (mode)
        M_CLEAR: begin
          mem_m[clr_m] = 8'h00;
          clr_m++;
          if (clr_m == 16) mode = M_RUN;
        end
        M_RUN: begin
          if (p) begin
            mode = M_PROG; mar_m = 0;
          end else begin
            if (wr) mem_m[mar_m] = b;
            if (ld)       mar_m = int'(b) % 16;
            else if (in_) mar_m = (mar_m + 1) % 16;
          end
        end
        default: begin
          if (!p) begin
            mode = M_RUN; mar_m = 0;
          end else if (pv) begin
            mem_m[mar_m] = pd;
            done_m = (mar_m == 15);
            mar_m = (mar_m + 1) % 16;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit r, ld, wr, in_, input logic [7:0] b,
                      input bit p, pv, input logic [7:0] pd);
    exp_t e;
    rst = r; load = ld; write = wr; inc = in_; bus = b;
    prog = p; prog_valid = pv; prog_data = pd;
    model(r, ld, wr, in_, b, p, pv, pd);
    e.busy      = (mode == M_CLEAR);
    e.ready     = (mode == M_PROG);
    e.done      = done_m;
    e.mar       = 4'(mar_m);
    e.out       = mem_m[mar_m];
    e.out_known = !$isunknown(mem_m[mar_m]);
    @(posedge clk);
    #1;
    sb.push_back(e);
    nstep++;
    @(negedge clk);
  endtask

  task automatic idle(input bit p);
    step(0, 0, 0, 0, 8'h00, p, 0, 8'h00);
  endtask

  task automatic read_all;
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(i), 0, 0, 8'h00);
  endtask

  initial begin
    bit pr;
    rst = 1; load = 0; write = 0; inc = 0; bus = 0;
    prog = 0; prog_valid = 0; prog_data = 0;
    @(negedge clk);

    // reset, fill, then read back zeros
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) idle(0);
    read_all();

    // run-mode load/write/inc interplay
    step(0, 1, 0, 0, 8'h3D, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'hA5, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h5A, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h0D, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h0F, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h07, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'hC3, 1, 0, 8'h00);  // prog entry suppresses run actions

    // gapped program stream 0x10..0x1F with wrap
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 8'h00, 1, (i % 2) == 0, 8'(16 + i / 2));
    step(0, 0, 0, 0, 8'h00, 1, 1, 8'h77);  // overwrite from address 0
    step(0, 0, 0, 0, 8'h00, 0, 1, 8'h99);  // exit: no accept
    step(0, 1, 0, 0, 8'h05, 0, 0, 8'h00);
    read_all();

    // reset mid-program, prog held through the fill
    idle(1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 8'h00, 1, 1, 8'(8'hE0 + i));
    step(1, 0, 0, 0, 8'h00, 1, 1, 8'hEE);
    for (int i = 0; i < 18; i++) idle(1);
    idle(0);
    read_all();

    // random traffic
    pr = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 11) == 0) pr = !pr;
      step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), pr, 1'($urandom), 8'($urandom));
    end
    idle(0);
    read_all();

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
